keccak_sched: RTL and testbench

Round-robin scheduler that shares one `keccak_core_NOPL` instance between `NREQ` hash requesters. It sequences the core through one job per grant:
- start pulse;
- message-word feed with last-block marking;
- routing of the truncated digest words back to the owning requester.

It sits between the requester-side message/digest streams and the core's `start`/`dt_i`/`valid`/`last_block`/`dt_o_hash`/`finish_hash`/`ready` pins.

---
 rtl/keccak_pkg.sv | 34 +++
 rtl/keccak_sched_if.sv | 37 +++
 rtl/keccak_sched_rr_arbiter.sv | 33 +++
 rtl/keccak_sched.sv | 207 ++++++++++++++++++++
 tb/tb_keccak_sched.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared constants, FSM state type and helpers for the Keccak core and its
// multi-requester scheduler.
package keccak_pkg;

    localparam int MAX_D          = 1344;
    localparam int DIGEST_WORDS_W = 6;
    localparam int D_W            = 11;
    localparam int CMODE_W        = 3;
    localparam int DATA_W         = 64;
    localparam int HASH_W         = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // A zero digest length selects the longest digest the core supports.
    function automatic logic [D_W-1:0] eff_digest_len(input logic [D_W-1:0] d);
        return (d == '0) ? D_W'(MAX_D) : d;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of 32-bit digest words for a d-bit digest, ceil(d/32).
    function automatic logic [DIGEST_WORDS_W-1:0] digest_words(input logic [D_W-1:0] d);
        return DIGEST_WORDS_W'((12'(d) + 12'd31) >> 5);
    endfunction

endpackage

// File: rtl/keccak_sched_if.sv
// Requester-side bundle of the Keccak scheduler: job requests, message word
// streams, digest word bus and per-requester status.
interface keccak_sched_if
    import keccak_pkg::*;
#(
    parameter int NREQ = 2
);

    logic [NREQ-1:0]         req;
    logic [NREQ*CMODE_W-1:0] req_cmode;
    logic [NREQ*D_W-1:0]     req_d;

    logic [NREQ*DATA_W-1:0]  s_data;
    logic [NREQ-1:0]         s_valid;
    logic [NREQ-1:0]         s_last;
    logic [NREQ-1:0]         s_ready;

    logic [HASH_W-1:0]       m_data;
    logic [NREQ-1:0]         m_valid;
    logic                    m_last;

    logic [NREQ-1:0]         done;
    logic [NREQ-1:0]         underrun;
    logic [NREQ-1:0]         grant;

    // The requesters drive jobs and message words and observe the results.
    modport master (
        output req, req_cmode, req_d, s_data, s_valid, s_last,
        input  s_ready, m_data, m_valid, m_last, done, underrun, grant
    );

    modport slave (
        input  req, req_cmode, req_d, s_data, s_valid, s_last,
        output s_ready, m_data, m_valid, m_last, done, underrun, grant
    );

endinterface

// File: rtl/keccak_sched_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first set request at or
// after ptr, wrapping around, as a one-hot vector.
module rr_arbiter
    import keccak_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]            req,
    input  logic [idx_width(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]            gnt
);

    localparam int IW = idx_width(NREQ);

    logic found;

    // One search chain per possible pointer value; only the matching one is live.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int s = 0; s < NREQ; s++) begin
            if (ptr == IW'(s)) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(s + k) % NREQ]) begin
                        gnt[(s + k) % NREQ] = 1'b1;
                        found               = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/keccak_sched.sv
// Round-robin scheduler sharing one Keccak core between NREQ requesters:
// grants a job, starts the core, feeds message words and routes digest words.
module keccak_sched
    import keccak_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    keccak_sched_if.slave         rq,

    output logic                  core_start,
    output logic [DATA_W-1:0]     core_dt_i,
    output logic [CMODE_W-1:0]    core_cmode,
    output logic [D_W-1:0]        core_d,
    output logic                  core_last_block,
    input  logic                  core_valid,
    input  logic                  core_ready,
    input  logic                  core_finish_hash,
    input  logic [HASH_W-1:0]     core_dt_o_hash
);

    localparam int IW = idx_width(NREQ);

    sched_state_t              state_q, state_d;
    logic [IW-1:0]             own_q, own_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]           grant_q, grant_d;
    logic [DIGEST_WORDS_W-1:0] words_left_q, words_left_d;
    logic                      core_start_q, core_start_d;
    logic [CMODE_W-1:0]        core_cmode_q, core_cmode_d;
    logic [D_W-1:0]            core_d_q, core_d_d;
    logic [HASH_W-1:0]         m_data_q, m_data_d;
    logic [NREQ-1:0]           m_valid_q, m_valid_d;
    logic                      m_last_q, m_last_d;
    logic [NREQ-1:0]           done_q, done_d;
    logic [NREQ-1:0]           underrun_q, underrun_d;

    logic [NREQ-1:0]           arb_gnt;
    logic [IW-1:0]             win_idx;
    logic [CMODE_W-1:0]        win_cmode;
    logic [D_W-1:0]            win_d;

    logic [DATA_W-1:0]         own_data;
    logic                      own_valid;
    logic                      own_last;
    logic                      feeding;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (rq.req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Job parameters of the requester the arbiter would pick this cycle.
    always_comb begin
        win_idx   = '0;
        win_cmode = '0;
        win_d     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx   = IW'(i);
                win_cmode = rq.req_cmode[i*CMODE_W +: CMODE_W];
                win_d     = rq.req_d[i*D_W +: D_W];
            end
        end
    end

    always_comb begin
        own_data  = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (own_q == IW'(i)) begin
                own_data  = rq.s_data[i*DATA_W +: DATA_W];
                own_valid = rq.s_valid[i];
                own_last  = rq.s_last[i];
            end
        end
    end

    assign feeding = (state_q == S_FEED);

    // The core has no input backpressure, so the message stream is a plain
    // mux of the owner's lane while feeding; grant_q doubles as the owner mask.
    always_comb begin
        core_dt_i       = '0;
        core_last_block = 1'b0;
        rq.s_ready      = '0;
        if (feeding) begin
            core_dt_i       = own_data;
            core_last_block = own_last;
            if (core_valid) begin
                rq.s_ready = grant_q;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        own_d        = own_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        words_left_d = words_left_q;
        core_start_d = 1'b0;
        core_cmode_d = core_cmode_q;
        core_d_d     = core_d_q;
        m_data_d     = m_data_q;
        m_valid_d    = '0;
        m_last_d     = 1'b0;
        done_d       = '0;
        underrun_d   = underrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (core_ready && (|rq.req)) begin
                    state_d      = S_START;
                    grant_d      = arb_gnt;
                    own_d        = win_idx;
                    core_start_d = 1'b1;
                    core_cmode_d = win_cmode;
                    core_d_d     = eff_digest_len(win_d);
                end
            end

            S_START: begin
                words_left_d = digest_words(core_d_q);
                state_d      = S_FEED;
            end

            S_FEED, S_DRAIN: begin
                if (feeding && core_valid && !own_valid) begin
                    underrun_d = underrun_q | grant_q;
                end
                // The first digest word both leaves FEED and is routed.
                if (core_finish_hash) begin
                    m_data_d     = core_dt_o_hash;
                    m_valid_d    = grant_q;
                    words_left_d = words_left_q - 1'b1;
                    if (words_left_q == DIGEST_WORDS_W'(1)) begin
                        m_last_d = 1'b1;
                        done_d   = grant_q;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_DRAIN;
                    end
                end
            end

            S_DONE: begin
                grant_d  = '0;
                rr_ptr_d = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            own_q        <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            words_left_q <= '0;
            core_start_q <= 1'b0;
            core_cmode_q <= '0;
            core_d_q     <= '0;
            m_data_q     <= '0;
            m_valid_q    <= '0;
            m_last_q     <= 1'b0;
            done_q       <= '0;
            underrun_q   <= '0;
        end else begin
            state_q      <= state_d;
            own_q        <= own_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            words_left_q <= words_left_d;
            core_start_q <= core_start_d;
            core_cmode_q <= core_cmode_d;
            core_d_q     <= core_d_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign core_start  = core_start_q;
    assign core_cmode  = core_cmode_q;
    assign core_d      = core_d_q;
    assign rq.grant    = grant_q;
    assign rq.m_data   = m_data_q;
    assign rq.m_valid  = m_valid_q;
    assign rq.m_last   = m_last_q;
    assign rq.done     = done_q;
    assign rq.underrun = underrun_q;

endmodule

// File: tb/tb_keccak_sched.sv
// Directed bench for keccak_sched with two requesters; the bench plays the
// Keccak core and checks grants, feed muxing, digest routing and resets.
module tb_keccak_sched;
    import keccak_pkg::*;

    localparam int NREQ = 2;

    logic               clk;
    logic               rst;
    logic               core_start;
    logic [DATA_W-1:0]  core_dt_i;
    logic [CMODE_W-1:0] core_cmode;
    logic [D_W-1:0]     core_d;
    logic               core_last_block;
    logic               core_valid;
    logic               core_ready;
    logic               core_finish_hash;
    logic [HASH_W-1:0]  core_dt_o_hash;

    int errors = 0;
    int checks = 0;

    int n_start  = 0;
    int n_sready = 0;
    int n_mvalid = 0;
    int n_done   = 0;

    keccak_sched_if #(.NREQ(NREQ)) rq ();

    keccak_sched #(
        .NREQ (NREQ)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rq               (rq),
        .core_start       (core_start),
        .core_dt_i        (core_dt_i),
        .core_cmode       (core_cmode),
        .core_d           (core_d),
        .core_last_block  (core_last_block),
        .core_valid       (core_valid),
        .core_ready       (core_ready),
        .core_finish_hash (core_finish_hash),
        .core_dt_o_hash   (core_dt_o_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (core_start)        n_start++;
        if (rq.s_ready[0])     n_sready++;
        if (rq.m_valid[0])     n_mvalid++;
        if (|rq.done)          n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [5:0] cmodes, input logic [21:0] ds);
        rq.req       = req;
        rq.req_cmode = cmodes;
        rq.req_d     = ds;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"},      64'(rq.grant),      64'd0);
        checkOutput({tag, "_core_start"}, 64'(core_start),    64'd0);
        checkOutput({tag, "_core_cmode"}, 64'(core_cmode),    64'd0);
        checkOutput({tag, "_core_d"},     64'(core_d),        64'd0);
        checkOutput({tag, "_m_valid"},    64'(rq.m_valid),    64'd0);
        checkOutput({tag, "_m_last"},     64'(rq.m_last),     64'd0);
        checkOutput({tag, "_done"},       64'(rq.done),       64'd0);
        checkOutput({tag, "_underrun"},   64'(rq.underrun),   64'd0);
        checkOutput({tag, "_s_ready"},    64'(rq.s_ready),    64'd0);
        checkOutput({tag, "_core_dt_i"},  64'(core_dt_i),     64'd0);
    endtask

    // Plays one full core job; entry and exit are in IDLE just after an edge.
    task automatic runJob(input int owner, input logic [2:0] cmode_exp, input logic [10:0] d_exp,
                          input int nfeed, input int nhash, input int words_exp, input int under_at);
        logic [1:0]  oh;
        logic [63:0] word;
        logic [31:0] hv;
        oh = (owner == 0) ? 2'b01 : 2'b10;
        core_ready = 1'b1;
        tick();
        checkOutput("grant",      64'(rq.grant),  64'(oh));
        checkOutput("core_start", 64'(core_start), 64'd1);
        checkOutput("core_cmode", 64'(core_cmode), 64'(cmode_exp));
        checkOutput("core_d",     64'(core_d),     64'(d_exp));
        core_ready = 1'b0;
        tick();
        checkOutput("core_start_pulse", 64'(core_start), 64'd0);
        for (int w = 1; w <= nfeed; w++) begin
            word = 64'hC0DE_0000_0000_0000 | (64'(owner) << 32) | 64'(w);
            rq.s_data = {2{64'hDEAD_BEEF_DEAD_BEEF}};
            if (owner == 0) rq.s_data[63:0]   = word;
            else            rq.s_data[127:64] = word;
            rq.s_valid = (w == under_at) ? ~oh : 2'b11;
            rq.s_last  = (w == nfeed) ? oh : ~oh;
            core_valid = 1'b1;
            #1;
            checkOutput("core_dt_i",       64'(core_dt_i),       word);
            checkOutput("core_last_block", 64'(core_last_block), 64'(w == nfeed));
            checkOutput("s_ready",         64'(rq.s_ready),      64'(oh));
            tick();
        end
        core_valid = 1'b0;
        rq.s_valid = 2'b00;
        rq.s_last  = 2'b00;
        #1;
        checkOutput("s_ready_idle", 64'(rq.s_ready), 64'd0);
        for (int h = 1; h <= nhash; h++) begin
            hv = 32'hA500_0000 | (32'(owner) << 16) | 32'(h);
            core_finish_hash = 1'b1;
            core_dt_o_hash   = hv;
            tick();
            if (h <= words_exp) begin
                checkOutput("m_valid", 64'(rq.m_valid), 64'(oh));
                checkOutput("m_data",  64'(rq.m_data),  64'(hv));
                checkOutput("m_last",  64'(rq.m_last),  64'(h == words_exp));
                checkOutput("done",    64'(rq.done),    64'((h == words_exp) ? oh : 2'b00));
            end else begin
                checkOutput("m_valid_dropped", 64'(rq.m_valid), 64'd0);
            end
        end
        core_finish_hash = 1'b0;
        if (nhash == words_exp) tick();
        checkOutput("grant_cleared", 64'(rq.grant), 64'd0);
        checkOutput("done_cleared",  64'(rq.done),  64'd0);
    endtask

    initial begin
        int base_start, base_sready, base_mvalid, base_done;

        rst              = 1'b1;
        core_valid       = 1'b0;
        core_ready       = 1'b0;
        core_finish_hash = 1'b0;
        core_dt_o_hash   = '0;
        rq.s_data        = '0;
        rq.s_valid       = '0;
        rq.s_last        = '0;
        applyStimulus(2'b00, 6'd0, 22'd0);
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;

        // Pending request with the core busy must not be granted.
        $display("[TB] blocked grant and single requester job");
        applyStimulus(2'b01, {3'd5, 3'd0}, {11'd96, 11'd224});
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("blocked_grant", 64'(rq.grant), 64'd0);
        end
        base_start  = n_start;
        base_sready = n_sready;
        base_mvalid = n_mvalid;
        base_done   = n_done;
        runJob(0, 3'd0, 11'd224, 2, 7, 7, 0);
        checkOutput("start_pulses",   64'(n_start - base_start),   64'd1);
        checkOutput("s_ready_pulses", 64'(n_sready - base_sready), 64'd2);
        checkOutput("m_valid_pulses", 64'(n_mvalid - base_mvalid), 64'd7);
        checkOutput("done_pulses",    64'(n_done - base_done),     64'd1);
        checkOutput("underrun_none",  64'(rq.underrun),            64'd0);
        applyStimulus(2'b00, {3'd5, 3'd0}, {11'd96, 11'd224});

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Both requesters hold req: owners must alternate 0,1,0,1.
        $display("[TB] round robin with underrun on requester 1");
        applyStimulus(2'b11, {3'd5, 3'd2}, {11'd96, 11'd64});
        runJob(0, 3'd2, 11'd64, 1, 2, 2, 0);
        runJob(1, 3'd5, 11'd96, 3, 3, 3, 3);
        checkOutput("underrun_set", 64'(rq.underrun), 64'h2);
        runJob(0, 3'd2, 11'd64, 1, 3, 2, 0);
        runJob(1, 3'd5, 11'd96, 2, 3, 3, 0);
        checkOutput("underrun_sticky", 64'(rq.underrun), 64'h2);

        $display("[TB] digest length boundaries");
        applyStimulus(2'b01, {3'd7, 3'd1}, {11'd1, 11'd1344});
        runJob(0, 3'd1, 11'd1344, 1, 43, 42, 0);
        applyStimulus(2'b10, {3'd7, 3'd1}, {11'd1, 11'd1344});
        runJob(1, 3'd7, 11'd1, 1, 2, 1, 0);
        applyStimulus(2'b01, {3'd7, 3'd1}, {11'd1, 11'd0});
        runJob(0, 3'd1, 11'd1344, 1, 42, 42, 0);

        // Reset while digest words are being routed.
        $display("[TB] reset during drain");
        applyStimulus(2'b01, {3'd4, 3'd3}, {11'd32, 11'd224});
        core_ready = 1'b1;
        tick();
        checkOutput("drain_grant", 64'(rq.grant), 64'h1);
        core_ready = 1'b0;
        tick();
        rq.s_valid = 2'b11;
        core_valid = 1'b1;
        tick();
        core_valid = 1'b0;
        for (int h = 1; h <= 3; h++) begin
            core_finish_hash = 1'b1;
            core_dt_o_hash   = 32'h5A00_0000 | 32'(h);
            tick();
        end
        checkOutput("drain_m_valid", 64'(rq.m_valid), 64'h1);
        checkOutput("drain_m_data",  64'(rq.m_data),  64'h5A00_0003);
        base_done = n_done;
        rst = 1'b1;
        tick();
        checkAllZero("midjob_reset");
        rst              = 1'b0;
        core_finish_hash = 1'b0;
        rq.s_valid       = 2'b00;
        tick();
        checkOutput("midjob_no_done", 64'(n_done - base_done), 64'd0);
        applyStimulus(2'b11, {3'd4, 3'd3}, {11'd32, 11'd32});
        runJob(0, 3'd3, 11'd32, 1, 1, 1, 0);
        applyStimulus(2'b10, {3'd4, 3'd3}, {11'd32, 11'd32});
        runJob(1, 3'd4, 11'd32, 1, 1, 1, 0);
        applyStimulus(2'b00, {3'd4, 3'd3}, {11'd32, 11'd32});
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
